// File: rtl/divide_seq.sv
// ============================================================================
// Module   : divide_seq
// Function : Iterative restoring divider (one quotient bit per clock) with
//            signed/unsigned mode, divide-by-zero and signed-overflow flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divide_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               c_CNT_W  = $clog2(WIDTH + 1);
  localparam logic [1:0]       c_IDLE   = 2'd0;
  localparam logic [1:0]       c_RUN    = 2'd1;
  localparam logic [1:0]       c_FINISH = 2'd2;
  localparam logic [WIDTH-1:0] c_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dq_q, dq_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rmdr_q, rmdr_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic             w_accept, w_a_neg, w_b_neg, w_zero, w_ovf, w_qbit, w_last;
  logic [WIDTH-1:0] w_amag, w_bmag, w_rem_nx, w_dq_nx;
  logic [WIDTH:0]   w_rem_sh, w_trial;

  // FINISH is the valid cycle, so a new request is accepted there as well.
  assign w_accept = start && (state_q != c_RUN);
  assign w_a_neg  = signed_op & a[WIDTH-1];
  assign w_b_neg  = signed_op & b[WIDTH-1];
  assign w_amag   = w_a_neg ? -a : a;
  assign w_bmag   = w_b_neg ? -b : b;
  assign w_zero   = (b == '0);
  assign w_ovf    = signed_op && (a == c_MIN) && (b == '1);

  // rem < |b| always holds, so the W+1-bit trial's top bit is a true sign.
  assign w_rem_sh = {rem_q, dq_q[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, bmag_q};
  assign w_qbit   = ~w_trial[WIDTH];
  assign w_rem_nx = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_dq_nx  = {dq_q[WIDTH-2:0], w_qbit};
  assign w_last   = (cnt_q == c_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      bmag_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rmdr_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      bmag_q  <= bmag_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rmdr_q  <= rmdr_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE, c_FINISH: state_d = (w_accept && !w_zero && !w_ovf) ? c_RUN : c_IDLE;
      c_RUN:            if (w_last) state_d = c_FINISH;
      default:          state_d = c_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    bmag_d  = bmag_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rmdr_d  = rmdr_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (state_q == c_RUN) begin
      cnt_d = cnt_q - c_CNT_W'(1);
      rem_d = w_rem_nx;
      dq_d  = w_dq_nx;
      if (w_last) begin
        valid_d = 1'b1;
        quot_d  = negq_q ? -w_dq_nx : w_dq_nx;
        rmdr_d  = negr_q ? -w_rem_nx : w_rem_nx;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
      end
    end else if (w_accept) begin
      if (w_zero) begin
        valid_d = 1'b1;
        quot_d  = '1;
        rmdr_d  = a;
        dbz_d   = 1'b1;
        ovf_d   = 1'b0;
      end else if (w_ovf) begin
        valid_d = 1'b1;
        quot_d  = c_MIN;
        rmdr_d  = '0;
        dbz_d   = 1'b0;
        ovf_d   = 1'b1;
      end else begin
        cnt_d  = c_CNT_W'(WIDTH);
        rem_d  = '0;
        dq_d   = w_amag;
        bmag_d = w_bmag;
        negq_d = w_a_neg ^ w_b_neg;
        negr_d = w_a_neg;
      end
    end
  end

  always_comb begin
    busy        = (state_q == c_RUN);
    valid       = valid_q;
    quotient    = quot_q;
    remainder   = rmdr_q;
    div_by_zero = dbz_q;
    overflow    = ovf_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_divide_seq.sv
// ============================================================================
// Module   : tb_divide_seq
// Function : Directed self-checking bench for divide_seq (WIDTH=32 and 8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_divide_seq;

  logic        clk = 1'b0;
  logic        reset, start, signed_op;
  logic [31:0] a, b, quotient, remainder;
  logic        busy, valid, dbz, ovf;

  logic        s8_start, s8_signed;
  logic [7:0]  s8_a, s8_b, s8_q, s8_r;
  logic        s8_busy, s8_valid, s8_dbz, s8_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divide_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .valid(valid),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(dbz), .overflow(ovf)
  );

  divide_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .signed_op(s8_signed),
    .a(s8_a), .b(s8_b), .busy(s8_busy), .valid(s8_valid),
    .quotient(s8_q), .remainder(s8_r),
    .div_by_zero(s8_dbz), .overflow(s8_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // glitch>0: pulse start with junk operands at that cycle of the operation
  task automatic op32(input string tag, input logic sgn, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic [31:0] eq, input logic [31:0] er, input logic edz, input logic eov,
                      input int elat, input int glitch);
    int lat, nbusy;
    @(negedge clk);
    start = 1'b1; signed_op = sgn; a = ta; b = tb_;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; nbusy = 0;
    while (!valid && lat < 100) begin
      if (busy) nbusy++;
      if (glitch != 0 && lat == glitch) begin
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h3; signed_op = ~sgn;
      end else if (glitch != 0 && lat == glitch + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " valid"}, 64'(valid), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " busy cycles"}, 64'(nbusy), 64'(elat == 1 ? 0 : elat - 1));
    chk({tag, " quotient"}, 64'(quotient), 64'(eq));
    chk({tag, " remainder"}, 64'(remainder), 64'(er));
    chk({tag, " flags"}, 64'({dbz, ovf}), 64'({edz, eov}));
  endtask

  task automatic ref8(input logic sgn, input logic [7:0] ta, input logic [7:0] tb_,
                      output logic [7:0] q, output logic [7:0] r, output logic [1:0] fl);
    int sa, sb, iq, ir;
    if (tb_ == 8'd0) begin
      q = 8'hFF; r = ta; fl = 2'b10;
    end else if (sgn && ta == 8'h80 && tb_ == 8'hFF) begin
      q = 8'h80; r = 8'h00; fl = 2'b01;
    end else if (sgn) begin
      sa = $signed(ta); sb = $signed(tb_);
      iq = sa / sb; ir = sa % sb;
      q = iq[7:0]; r = ir[7:0]; fl = 2'b00;
    end else begin
      q = ta / tb_; r = ta % tb_; fl = 2'b00;
    end
  endtask

  task automatic op8(input logic sgn, input logic [7:0] ta, input logic [7:0] tb_);
    logic [7:0] eq, er;
    logic [1:0] ef;
    int lat;
    string tag;
    ref8(sgn, ta, tb_, eq, er, ef);
    tag = $sformatf("w8 %s %0d/%0d", sgn ? "s" : "u", ta, tb_);
    @(negedge clk);
    s8_start = 1'b1; s8_signed = sgn; s8_a = ta; s8_b = tb_;
    @(posedge clk); #1;
    s8_start = 1'b0;
    lat = 1;
    while (!s8_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(ef != 2'b00 ? 1 : 9));
    chk({tag, " q"}, 64'(s8_q), 64'(eq));
    chk({tag, " r"}, 64'(s8_r), 64'(er));
    chk({tag, " flags"}, 64'({s8_dbz, s8_ovf}), 64'(ef));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] edge_v [6];
    int nvalid;
    edge_v = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd129, 8'd255};
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    s8_start = 1'b0; s8_signed = 1'b0; s8_a = '0; s8_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset q", 64'(quotient), 64'd0);
    chk("reset r", 64'(remainder), 64'd0);
    chk("reset flags", 64'({dbz, ovf}), 64'd0);
    reset = 1'b0;

    // consecutive calls start on the valid cycle, so each is back-to-back
    op32("u 100/7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33, 0);
    op32("s -7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 33, 0);
    op32("s 7/-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 33, 0);
    op32("u 1234/0",  1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0, 1,  0);
    op32("u 9/3",     1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 1'b0, 33, 0);
    op32("s MIN/-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 1,  0);
    op32("u MIN/-1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0, 33, 0);
    op32("s -100/-7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0, 33, 0);
    op32("s MIN/2",   1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 1'b0, 33, 0);
    op32("u max/1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 33, 0);
    op32("s -5/0",    1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1'b0, 1,  0);
    op32("u glitch",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33, 5);

    // single-cycle valid and held results
    @(posedge clk); #1;
    chk("pulse valid low", 64'(valid), 64'd0);
    chk("held q", 64'(quotient), 64'd14);
    chk("held r", 64'(remainder), 64'd2);

    // abort at RUN cycle 10
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre-abort busy", 64'(busy), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort q", 64'(quotient), 64'd0);
    chk("abort r", 64'(remainder), 64'd0);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid || busy) nvalid++;
    end
    chk("abort no activity", 64'(nvalid), 64'd0);

    // reset and start on the same edge
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst+start busy", 64'(busy), 64'd0);
    chk("rst+start valid", 64'(valid), 64'd0);

    op32("u 9/3 after", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33, 0);

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        op8(1'b0, edge_v[i], edge_v[j]);
        op8(1'b1, edge_v[i], edge_v[j]);
      end
    for (int ai = 0; ai < 256; ai += 7)
      for (int bi = 0; bi < 256; bi += 11) begin
        op8(1'b0, 8'(ai), 8'(bi));
        op8(1'b1, 8'(ai), 8'(bi));
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
